// File: rtl/sort_pkg.sv
// Shared helpers for the bitonic sorting network: stage count and the
// per-layer geometry (block size, partner distance, sub-sequence direction).
// These are evaluated at elaboration time, so the generate grid needs no tables.
package sort_pkg;

  localparam int MAX_LOGN = 5;

  // Number of compare-exchange layers for 2**logn elements.
  function automatic int stage_count(input int logn);
    return (logn * (logn + 1)) / 2;
  endfunction

  // log2 of the bitonic block size merged by layer s.
  function automatic int layer_blk_log(input int s);
    int rem;
    int res;
    rem = s;
    res = 0;
    for (int p = 1; p <= MAX_LOGN; p++) begin
      if (res == 0) begin
        if (rem < p) res = p;
        else rem = rem - p;
      end
    end
    return res;
  endfunction

  // log2 of the compare distance used by layer s.
  function automatic int layer_dist_log(input int s);
    int rem;
    int res;
    bit found;
    rem = s;
    res = 0;
    found = 1'b0;
    for (int p = 1; p <= MAX_LOGN; p++) begin
      if (!found) begin
        if (rem < p) begin
          res = p - 1 - rem;
          found = 1'b1;
        end else begin
          rem = rem - p;
        end
      end
    end
    return res;
  endfunction

  // Bitonic block size merged by layer s.
  function automatic int block_size(input int s);
    return 1 << layer_blk_log(s);
  endfunction

  // Index compared against element i in layer s.
  function automatic int partner(input int s, input int i);
    return i ^ (1 << layer_dist_log(s));
  endfunction

  // Sub-sequence direction at element i in layer s (1 = descending block).
  function automatic logic sub_dir(input int s, input int i);
    return ((i >> layer_blk_log(s)) & 1) != 0;
  endfunction

endpackage

// File: rtl/bitonic_sort_pipe_cx.sv
// Combinational compare-exchange cell. lo/hi map to the lower/higher network
// index. With dir=0 the smaller key goes to lo; with dir=1 the larger key does.
// Equal keys are never reordered in the ascending case.
module bitonic_cx #(
  parameter int DW     = 8,
  parameter int SIGNED = 0
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          dir,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi
);

  logic gt;
  logic swap;

  // Strict greater-than in the configured number format, then steer.
  always_comb begin
    if (SIGNED != 0) gt = $signed(a) > $signed(b);
    else             gt = a > b;
    swap = dir ^ gt;
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter: one register stage per compare-exchange
// layer, a single global advance enable, and a tag/dir sideband per stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The pipeline advances whenever the output register is empty or
// being drained (adv = out_ready | ~out_valid); in_ready equals adv, so the
// producer must hold in_valid and its payload until it sees in_ready=1.
// Bubbles travel with the pipe and are not squeezed out.
module bitonic_sort_pipe
  import sort_pkg::*;
#(
  parameter int DW     = 8,
  parameter int LOGN   = 3,
  parameter int TW     = 4,
  parameter int SIGNED = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [(2**LOGN)*DW-1:0]    in_data,
  input  logic                       in_dir,
  input  logic [TW-1:0]              in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(2**LOGN)*DW-1:0]    out_data,
  output logic [TW-1:0]              out_tag,
  output logic                       busy
);

  localparam int N = 2 ** LOGN;
  localparam int S = stage_count(LOGN);

  // Stage registers.
  logic [N-1:0][DW-1:0] st_data [S];
  logic                 st_dir  [S];
  logic [TW-1:0]        st_tag  [S];
  logic [S-1:0]         st_valid;

  // Per-layer combinational inputs and network outputs.
  logic [N-1:0][DW-1:0] lay_in    [S];
  logic [N-1:0][DW-1:0] lay_out   [S];
  logic                 lay_dir   [S];
  logic [TW-1:0]        lay_tag   [S];
  logic                 lay_valid [S];

  logic adv;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = st_valid[S-1];
  assign out_data  = st_data[S-1];
  assign out_tag   = st_tag[S-1];
  assign busy      = |st_valid;

  for (genvar s = 0; s < S; s++) begin : g_layer
    if (s == 0) begin : g_src_in
      assign lay_in[s]    = in_data;
      assign lay_dir[s]   = in_dir;
      assign lay_tag[s]   = in_tag;
      assign lay_valid[s] = in_valid;
    end else begin : g_src_reg
      assign lay_in[s]    = st_data[s-1];
      assign lay_dir[s]   = st_dir[s-1];
      assign lay_tag[s]   = st_tag[s-1];
      assign lay_valid[s] = st_valid[s-1];
    end

    for (genvar i = 0; i < N; i++) begin : g_elem
      localparam int   PI = partner(s, i);
      localparam logic SD = sub_dir(s, i);
      if (i < PI) begin : g_cx
        bitonic_cx #(
          .DW     (DW),
          .SIGNED (SIGNED)
        ) u_cx (
          .a   (lay_in[s][i]),
          .b   (lay_in[s][PI]),
          .dir (lay_dir[s] ^ SD),
          .lo  (lay_out[s][i]),
          .hi  (lay_out[s][PI])
        );
      end
    end
  end

  // Every stage loads its layer result together when the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      for (int s = 0; s < S; s++) begin
        st_data[s] <= '0;
        st_dir[s]  <= 1'b0;
        st_tag[s]  <= '0;
      end
    end else if (adv) begin
      for (int s = 0; s < S; s++) begin
        st_data[s]  <= lay_out[s];
        st_dir[s]   <= lay_dir[s];
        st_tag[s]   <= lay_tag[s];
        st_valid[s] <= lay_valid[s];
      end
    end
  end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Bench for bitonic_sort_pipe (N=8, DW=8, TW=4). Two instances share all
// inputs: one unsigned, one signed, each with its own expected queue.
module tb_bitonic_sort_pipe;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int TW = 4;
  localparam int VW = N * DW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [VW-1:0] in_data;
  logic          in_dir;
  logic [TW-1:0] in_tag;
  logic          out_ready;

  logic          in_ready_u, out_valid_u, busy_u;
  logic [VW-1:0] out_data_u;
  logic [TW-1:0] out_tag_u;
  logic          in_ready_s, out_valid_s, busy_s;
  logic [VW-1:0] out_data_s;
  logic [TW-1:0] out_tag_s;

  logic [TW+VW-1:0] exp_u_q[$];
  logic [TW+VW-1:0] exp_s_q[$];

  int checks;
  int errors;
  int run_len;
  int max_run;

  bitonic_sort_pipe #(.DW(DW), .LOGN(3), .TW(TW), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_dir(in_dir), .in_tag(in_tag),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
    .out_tag(out_tag_u), .busy(busy_u)
  );

  bitonic_sort_pipe #(.DW(DW), .LOGN(3), .TW(TW), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_dir(in_dir), .in_tag(in_tag),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_tag(out_tag_s), .busy(busy_s)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference sort: plain bubble sort of the 8 elements.
  function automatic logic [VW-1:0] model_sort(input logic [VW-1:0] v, input logic dir,
                                               input bit sgn);
    logic [DW-1:0] e[N];
    logic [DW-1:0] t;
    logic [VW-1:0] r;
    bit gt, lt;
    for (int i = 0; i < N; i++) e[i] = v[i*DW +: DW];
    for (int i = 0; i < N - 1; i++) begin
      for (int j = 0; j < N - 1 - i; j++) begin
        gt = sgn ? ($signed(e[j]) > $signed(e[j+1])) : (e[j] > e[j+1]);
        lt = sgn ? ($signed(e[j]) < $signed(e[j+1])) : (e[j] < e[j+1]);
        if (dir ? lt : gt) begin
          t = e[j];
          e[j] = e[j+1];
          e[j+1] = t;
        end
      end
    end
    for (int i = 0; i < N; i++) r[i*DW +: DW] = e[i];
    return r;
  endfunction

  // Driver: call #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [VW-1:0] d, input logic dir, input logic [TW-1:0] tag,
                      input logic [VW-1:0] exp_u, input logic [VW-1:0] exp_s);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready_u && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected in_ready=1");
    end
    @(posedge clk);
    exp_u_q.push_back({tag, exp_u});
    exp_s_q.push_back({tag, exp_s});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    logic [TW+VW-1:0] ent;
    if (rst_n && out_valid_u && out_ready) begin
      if (exp_u_q.size() == 0) begin
        check("unexpected_out_u", 64'(out_tag_u), 64'hFFFF);
      end else begin
        ent = exp_u_q.pop_front();
        check("data_u", out_data_u, ent[VW-1:0]);
        check("tag_u", 64'(out_tag_u), 64'(ent[TW+VW-1:VW]));
      end
    end
    if (rst_n && out_valid_s && out_ready) begin
      if (exp_s_q.size() == 0) begin
        check("unexpected_out_s", 64'(out_tag_s), 64'hFFFF);
      end else begin
        ent = exp_s_q.pop_front();
        check("data_s", out_data_s, ent[VW-1:0]);
        check("tag_s", 64'(out_tag_s), 64'(ent[TW+VW-1:VW]));
      end
    end
    if (out_valid_u) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
  end

  // Directed vectors (element 0 in the low byte) with hand-sorted results.
  localparam logic [VW-1:0] V_DESC    = 64'h00_01_02_03_04_05_06_07; // {7..0}
  localparam logic [VW-1:0] V_ASC     = 64'h07_06_05_04_03_02_01_00; // {0..7}
  localparam logic [VW-1:0] V_DUP     = 64'h00_00_02_02_01_01_03_03; // {3,3,1,1,2,2,0,0}
  localparam logic [VW-1:0] V_DUP_ASC = 64'h03_03_02_02_01_01_00_00;
  localparam logic [VW-1:0] V_MIX     = 64'h02_01_FB_05_00_80_7F_FF; // {-1,127,-128,0,5,-5,1,2}
  localparam logic [VW-1:0] V_MIX_SA  = 64'h7F_05_02_01_00_FF_FB_80; // signed ascending
  localparam logic [VW-1:0] V_MIX_UA  = 64'hFF_FB_80_7F_05_02_01_00; // unsigned ascending
  localparam logic [VW-1:0] V_MIX_SD  = 64'h80_FB_FF_00_01_02_05_7F; // signed descending
  localparam logic [VW-1:0] V_MIX_UD  = 64'h00_01_02_05_7F_80_FB_FF; // unsigned descending

  initial begin
    int cnt;
    int seen;
    logic [VW-1:0] hold_d;
    logic [TW-1:0] hold_t;
    logic [VW-1:0] rv;

    checks = 0; errors = 0; run_len = 0; max_run = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; in_tag = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid_u), 64'd0);
    check("rst_out_data", out_data_u, 64'd0);
    check("rst_out_tag", 64'(out_tag_u), 64'd0);
    check("rst_busy", 64'(busy_u), 64'd0);
    check("rst_in_ready", 64'(in_ready_u), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single vector: latency and one-cycle valid pulse.
    send(V_DESC, 1'b0, 4'd5, V_ASC, V_ASC);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid_u && cnt < 20);
    check("latency", 64'(cnt), 64'd6);
    check("busy_inflight", 64'(busy_u), 64'd1);
    @(negedge clk);
    check("single_pulse", 64'(out_valid_u), 64'd0);
    @(posedge clk);
    #1;

    // Direction, duplicates, signed vs unsigned order.
    send(V_DESC, 1'b1, 4'd6, V_DESC, V_DESC);
    send(V_DUP, 1'b0, 4'd7, V_DUP_ASC, V_DUP_ASC);
    send(V_MIX, 1'b0, 4'd8, V_MIX_UA, V_MIX_SA);
    send(V_MIX, 1'b1, 4'd9, V_MIX_UD, V_MIX_SD);
    drain();

    // Back-to-back stream, alternating direction.
    max_run = 0;
    for (int k = 0; k < 10; k++) begin
      rv = {$urandom, $urandom};
      send(rv, k[0], TW'(k), model_sort(rv, k[0], 1'b0), model_sort(rv, k[0], 1'b1));
    end
    drain();
    check("b2b_run", 64'(max_run), 64'd10);

    // Backpressure: stall the output for 4 cycles mid-stream.
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          rv = {$urandom, $urandom};
          send(rv, k[1], TW'(k + 3), model_sort(rv, k[1], 1'b0), model_sort(rv, k[1], 1'b1));
        end
      end
      begin
        cnt = 0;
        do begin
          @(posedge clk);
          #1;
          cnt++;
        end while (!out_valid_u && cnt < 50);
        out_ready = 1'b0;
        hold_d = out_data_u;
        hold_t = out_tag_u;
        repeat (4) begin
          @(negedge clk);
          check("stall_data", out_data_u, hold_d);
          check("stall_tag", 64'(out_tag_u), 64'(hold_t));
          check("stall_in_ready", 64'(in_ready_u), 64'd0);
          check("stall_valid", 64'(out_valid_u), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_queue_empty", 64'(exp_u_q.size() + exp_s_q.size()), 64'd0);

    // Reset with three transactions in flight.
    send(V_DESC, 1'b0, 4'd1, V_ASC, V_ASC);
    send(V_DUP, 1'b0, 4'd2, V_DUP_ASC, V_DUP_ASC);
    send(V_MIX, 1'b0, 4'd3, V_MIX_UA, V_MIX_SA);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid_u), 64'd0);
    check("midrst_busy_u", 64'(busy_u), 64'd0);
    check("midrst_busy_s", 64'(busy_s), 64'd0);
    check("midrst_in_ready", 64'(in_ready_u), 64'd1);
    exp_u_q.delete();
    exp_s_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid_u || out_valid_s) seen++;
    end
    check("post_rst_quiet", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    send(V_MIX, 1'b1, 4'd9, V_MIX_UD, V_MIX_SD);
    drain();
    check("final_queue_empty", 64'(exp_u_q.size() + exp_s_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
